// File: rtl/ecc_fix_pipe.sv
// Two-stage single-error corrector: S1 decodes the syndrome to a bit index,
// S2 flips/masks the word and tags it; valid/ready on both sides, full rate.
module ecc_fix_pipe #(
   parameter int CW_MAX = 32,
   parameter int SYN_W  = 5,
   parameter int W_S    = 8,
   parameter int W_M    = 16,
   parameter int W_L    = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_MAX-1:0] in_data,
   input  logic [SYN_W-1:0]  in_syn,
   input  logic [1:0]        in_nof,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW_MAX-1:0] out_data,
   output logic [1:0]        out_status,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_uncorr
);

   localparam logic [1:0] ST_CLEAN  = 2'b00;
   localparam logic [1:0] ST_CORR   = 2'b01;
   localparam logic [1:0] ST_UNCORR = 2'b10;

   logic              adv1;
   logic              adv2;
   logic              out_hs;

   logic              s1_valid_q,  s1_valid_d;
   logic [CW_MAX-1:0] s1_data_q,   s1_data_d;
   logic [1:0]        s1_mode_q,   s1_mode_d;
   logic [1:0]        s1_nof_q,    s1_nof_d;
   logic [SYN_W-1:0]  s1_idx_q,    s1_idx_d;

   logic              out_valid_q,  out_valid_d;
   logic [CW_MAX-1:0] out_data_q,   out_data_d;
   logic [1:0]        out_status_q, out_status_d;

   logic [CNT_W-1:0]  cnt_corr_q,   cnt_corr_d;
   logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

   logic [SYN_W-1:0]  syn_msb;
   logic              syn_pow2;
   logic [SYN_W-1:0]  dec_idx;

   logic [31:0]       act_w;
   logic [31:0]       idx_ext;
   logic [CW_MAX-1:0] act_mask;
   logic [CW_MAX-1:0] flip_vec;
   logic [CW_MAX-1:0] res_data;
   logic [1:0]        res_status;

   // Handshake: a stage may load when it is empty or its successor is moving.
   assign adv2     = !out_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1;
   assign out_hs   = out_valid_q && out_ready;

   // ---------------- syndrome decode ----------------
   always_comb begin
      syn_msb = '0;
      for (int i = 0; i < SYN_W; i++) begin
         if (in_syn[i]) begin
            syn_msb = SYN_W'(i);
         end
      end
   end

   assign syn_pow2 = ((in_syn & (in_syn - SYN_W'(1))) == '0);

   // Parity positions sit at powers of two; data positions fill the gaps after
   // the SYN_W check bits, so non-power syndromes skip the powers below them.
   always_comb begin
      if (in_syn == '0) begin
         dec_idx = SYN_W'(SYN_W);
      end else if (syn_pow2) begin
         dec_idx = syn_msb;
      end else begin
         dec_idx = SYN_W'(SYN_W) + in_syn - syn_msb - SYN_W'(1);
      end
   end

   // ---------------- stage 1 ----------------
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_mode_d  = s1_mode_q;
      s1_nof_d   = s1_nof_q;
      s1_idx_d   = s1_idx_q;
      if (adv1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_mode_d = in_mode;
            s1_nof_d  = in_nof;
            s1_idx_d  = dec_idx;
         end
      end
   end

   // ---------------- stage 2 ----------------
   always_comb begin
      case (s1_mode_q)
         2'b00:   act_w = 32'(W_S);
         2'b01:   act_w = 32'(W_M);
         2'b10:   act_w = 32'(W_L);
         default: act_w = 32'(CW_MAX);
      endcase
   end

   assign idx_ext = 32'(s1_idx_q);

   for (genvar gi = 0; gi < CW_MAX; gi++) begin : g_bit
      assign act_mask[gi] = (32'(gi) < act_w);
      assign flip_vec[gi] = (32'(gi) == idx_ext);
   end

   always_comb begin
      res_data   = s1_data_q & act_mask;
      res_status = ST_UNCORR;
      if (s1_mode_q == 2'b11) begin
         res_data = s1_data_q;
      end else if (s1_nof_q == 2'd0) begin
         res_status = ST_CLEAN;
      end else if ((s1_nof_q == 2'd1) && (idx_ext < act_w)) begin
         res_data   = (s1_data_q ^ flip_vec) & act_mask;
         res_status = ST_CORR;
      end
   end

   // Output registers only move on adv2, so they hold while the sink stalls.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_status_d = out_status_q;
      if (adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d   = res_data;
            out_status_d = res_status;
         end
      end
   end

   // ---------------- statistics ----------------
   always_comb begin
      cnt_corr_d   = cnt_corr_q;
      cnt_uncorr_d = cnt_uncorr_q;
      if (cnt_clr) begin
         cnt_corr_d   = '0;
         cnt_uncorr_d = '0;
      end else if (out_hs) begin
         if ((out_status_q == ST_CORR) && (cnt_corr_q != '1)) begin
            cnt_corr_d = cnt_corr_q + CNT_W'(1);
         end
         if ((out_status_q == ST_UNCORR) && (cnt_uncorr_q != '1)) begin
            cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_mode_q    <= '0;
         s1_nof_q     <= '0;
         s1_idx_q     <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_status_q <= '0;
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         s1_mode_q    <= s1_mode_d;
         s1_nof_q     <= s1_nof_d;
         s1_idx_q     <= s1_idx_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_status_q <= out_status_d;
         cnt_corr_q   <= cnt_corr_d;
         cnt_uncorr_q <= cnt_uncorr_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_status = out_status_q;
   assign cnt_corr   = cnt_corr_q;
   assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_ecc_fix_pipe.sv
// Scoreboard bench for ecc_fix_pipe: accepted words push a model result,
// output handshakes pop and compare; counters use 4 bits to reach saturation.
module tb_ecc_fix_pipe;

   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] d;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_syn;
   logic [1:0]  in_nof;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_status;
   logic        cnt_clr;
   logic [3:0]  cnt_corr;
   logic [3:0]  cnt_uncorr;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   int   exp_corr   = 0;
   int   exp_uncorr = 0;

   ecc_fix_pipe #(
      .CW_MAX(32), .SYN_W(5), .W_S(8), .W_M(16), .W_L(32), .CNT_W(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_syn    (in_syn),
      .in_nof    (in_nof),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_status(out_status),
      .cnt_clr   (cnt_clr),
      .cnt_corr  (cnt_corr),
      .cnt_uncorr(cnt_uncorr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: data bits follow the check bits, skipping power-of-two syndromes.
   function automatic exp_t model(input logic [31:0] d, input logic [4:0] syn,
                                  input logic [1:0] nof, input logic [1:0] mode);
      exp_t        e;
      int          w;
      int          idx;
      int          npow;
      logic [31:0] mask;
      case (mode)
         2'b00:   w = 8;
         2'b01:   w = 16;
         2'b10:   w = 32;
         default: w = 0;
      endcase
      if (mode == 2'b11) begin
         e.d  = d;
         e.st = 2'b10;
         return e;
      end
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      if (syn == 5'd0) begin
         idx = 5;
      end else if ($countones(syn) == 1) begin
         idx = 0;
         for (int b = 0; b < 5; b++) if (syn == (5'd1 << b)) idx = b;
      end else begin
         npow = 0;
         for (int v = 3; v <= int'(syn); v++) if ($countones(v) != 1) npow++;
         idx = 5 + npow;
      end
      if (nof == 2'd0) begin
         e.d  = d & mask;
         e.st = 2'b00;
      end else if (nof == 2'd1 && idx < w) begin
         e.d  = (d ^ (32'h1 << idx)) & mask;
         e.st = 2'b01;
      end else begin
         e.d  = d & mask;
         e.st = 2'b10;
      end
      return e;
   endfunction

   // One clock: observe both handshakes at the falling edge, then step past the rising edge.
   task automatic cycle(output bit acc);
      exp_t e;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sb.push_back(model(in_data, in_syn, in_nof, in_mode));
      if (out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got data=%h st=%b, required no output", out_data, out_status);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_status !== e.st) begin
               bad++;
               $display("FAIL sb_word: got data=%h st=%b, required data=%h st=%b",
                        out_data, out_status, e.d, e.st);
            end else begin
               $display("xfer data=%h st=%b", out_data, out_status);
            end
            if (e.st == 2'b01 && exp_corr < 15) exp_corr++;
            if (e.st == 2'b10 && exp_uncorr < 15) exp_uncorr++;
         end
      end
      if (cnt_clr) begin
         exp_corr   = 0;
         exp_uncorr = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      bit a;
      cycle(a);
   endtask

   task automatic send(input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] n, input logic [1:0] m);
      bit a;
      int waitc;
      in_valid = 1'b1;
      in_data  = d;
      in_syn   = s;
      in_nof   = n;
      in_mode  = m;
      waitc    = 0;
      do begin
         cycle(a);
         waitc++;
      end while (!a && waitc < 20);
      total++;
      if (!a) begin
         bad++;
         $display("FAIL send_accept: got no accept in %0d cycles, required accept", waitc);
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 40 && sb.size() > 0; c++) tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d words pending, required 0", sb.size());
      end
   endtask

   task automatic check_counters(input string tag);
      total++;
      if (cnt_corr !== 4'(exp_corr) || cnt_uncorr !== 4'(exp_uncorr)) begin
         bad++;
         $display("FAIL %s: got corr=%0d uncorr=%0d, required corr=%0d uncorr=%0d",
                  tag, cnt_corr, cnt_uncorr, exp_corr, exp_uncorr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_syn = '0; in_nof = '0; in_mode = '0;
      out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
      total++;
      if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h, required 0", out_data); end
      total++;
      if (out_status !== 2'b00) begin bad++; $display("FAIL rst_status: got %b, required 00", out_status); end
      total++;
      if (cnt_corr !== 4'd0 || cnt_uncorr !== 4'd0) begin
         bad++;
         $display("FAIL rst_cnt: got %0d/%0d, required 0/0", cnt_corr, cnt_uncorr);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      bit a;
      in_valid = 1'b1; in_data = 32'h0; in_syn = 5'b00011; in_nof = 2'd1; in_mode = 2'b10;
      cycle(a);
      in_valid = 1'b0;
      total++;
      if (a !== 1'b1) begin bad++; $display("FAIL basic_accept: got %b, required 1", a); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got valid %b, required 0", out_valid); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_0040 || out_status !== 2'b01) begin
         bad++;
         $display("FAIL basic_out: got v=%b d=%h st=%b, required v=1 d=00000040 st=01",
                  out_valid, out_data, out_status);
      end
      tick();
      total++;
      if (cnt_corr !== 4'd1) begin bad++; $display("FAIL basic_cnt: got %0d, required 1", cnt_corr); end
   endtask

   task automatic test_modes();
      logic [31:0] td [11] = '{32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FFFF, 32'h1234_5678,
                               32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hCAFE_F00D};
      logic [4:0]  ts [11] = '{5'd5, 5'd9, 5'd3, 5'd7, 5'd3, 5'd0, 5'd16, 5'd17, 5'd31, 5'd31, 5'd12};
      logic [1:0]  tn [11] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
      logic [1:0]  tm [11] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
      for (int i = 0; i < 11; i++) send(td[i], ts[i], tn[i], tm[i]);
      drain();
      check_counters("modes_cnt");
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_syn    = 5'($urandom_range(0, 31));
         in_nof    = 2'($urandom_range(0, 3));
         in_mode   = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain();
      check_counters("random_cnt");
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      logic [4:0]  s [4] = '{5'd3, 5'd6, 5'd0, 5'd24};
      logic [31:0] held_d;
      logic [1:0]  held_s;
      bit a;
      int k;
      out_ready = 1'b0;
      k = 0;
      held_d = '0;
      held_s = '0;
      in_nof  = 2'd1;
      in_mode = 2'b10;
      for (int c = 0; c < 6; c++) begin
         if (k < 4) begin
            in_valid = 1'b1; in_data = w[k]; in_syn = s[k];
         end else begin
            in_valid = 1'b0;
         end
         cycle(a);
         if (a) k++;
         if (c == 1) begin
            held_d = out_data;
            held_s = out_status;
         end
         if (c >= 2) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_status !== held_s) begin
               bad++;
               $display("FAIL stall_hold: got v=%b d=%h st=%b, required v=1 d=%h st=%b",
                        out_valid, out_data, out_status, held_d, held_s);
            end
         end
      end
      total++;
      if (k != 2) begin bad++; $display("FAIL stall_accepted: got %0d, required 2", k); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && k < 4; c++) begin
         in_valid = 1'b1; in_data = w[k]; in_syn = s[k];
         cycle(a);
         if (a) k++;
      end
      drain();
      total++;
      if (k != 4) begin bad++; $display("FAIL stall_release: got %0d accepted, required 4", k); end
   endtask

   task automatic test_saturation();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      total++;
      if (cnt_corr !== 4'd0 || cnt_uncorr !== 4'd0) begin
         bad++;
         $display("FAIL clr_idle: got %0d/%0d, required 0/0", cnt_corr, cnt_uncorr);
      end
      for (int i = 0; i < 17; i++) send($urandom, 5'd3, 2'd1, 2'b10);
      drain();
      total++;
      if (cnt_corr !== 4'd15) begin bad++; $display("FAIL sat_corr: got %0d, required 15", cnt_corr); end
      check_counters("sat_model");
      out_ready = 1'b0;
      send(32'h0, 5'd5, 2'd1, 2'b10);
      in_valid = 1'b0;
      for (int c = 0; c < 5 && out_valid !== 1'b1; c++) tick();
      cnt_clr   = 1'b1;
      out_ready = 1'b1;
      tick();
      cnt_clr = 1'b0;
      total++;
      if (cnt_corr !== 4'd0) begin bad++; $display("FAIL clr_vs_inc: got %0d, required 0", cnt_corr); end
      drain();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      send(32'h0, 5'd3, 2'd1, 2'b10);
      in_valid = 1'b0;
      tick();
      tick();
      check_counters("pre_rst_cnt");
      send(32'hDEAD_BEEF, 5'd3, 2'd1, 2'b10);
      send(32'hFEED_FACE, 5'd5, 2'd2, 2'b10);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== 32'h0) begin
         bad++;
         $display("FAIL arst_out: got v=%b d=%h, required v=0 d=0", out_valid, out_data);
      end
      total++;
      if (cnt_corr !== 4'd0 || cnt_uncorr !== 4'd0) begin
         bad++;
         $display("FAIL arst_cnt: got %0d/%0d, required 0/0", cnt_corr, cnt_uncorr);
      end
      sb.delete();
      exp_corr   = 0;
      exp_uncorr = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(32'h0000_0001, 5'd0, 2'd0, 2'b00);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_lat1: got valid %b, required 0", out_valid); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_0001 || out_status !== 2'b00) begin
         bad++;
         $display("FAIL arst_lat2: got v=%b d=%h st=%b, required v=1 d=00000001 st=00",
                  out_valid, out_data, out_status);
      end
      drain();
      check_counters("post_rst_cnt");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_modes();
      test_random();
      test_back_to_back();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
